fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of write requesters (2..8).
REQ-002 Parameter DW, 8, data width, equal to the shared sync_fifo din width.
REQ-003 Parameter BURST, 4, maximum accepted words per grant (1..255).
REQ-004 Port clk input 1, single clock; all logic on rising edge.
REQ-005 Port rst input 1, reset; synchronous and active-high.
REQ-006 Port req input NREQ, per-requester word-valid.
REQ-007 Port data input NREQ*DW, packed requester words; requester i occupies bits [i*DW +: DW].
REQ-008 Port ack output NREQ, per-requester word-accepted strobe.
REQ-009 Port gnt output NREQ, registered one-hot grant (all zero when idle).
REQ-010 Port fifo_full input 1, full flag from the shared sync_fifo.
REQ-011 Port fifo_we output 1, FIFO write enable.
REQ-012 Port fifo_din output DW, FIFO write data.

Function
REQ-013 FSM SHALL have two states: IDLE (gnt=0) and BUSY (exactly one gnt bit set).
REQ-014 ack[i] SHALL equal gnt[i] & req[i] & !fifo_full, combinationally.
REQ-015 fifo_we SHALL equal OR of ack; fifo_din SHALL equal data of the granted requester, or zero when idle.
REQ-016 IDLE->BUSY: at an edge with any req set, gnt SHALL be loaded with the round-robin winner searched from pointer ptr upward with wrap; the first write is possible in the following cycle.
REQ-017 A burst counter SHALL count accepted words of the current grant; a stalled cycle (fifo_full=1) SHALL neither advance it nor release the grant.
REQ-018 The grant SHALL end at the edge where the BURST-th word is accepted, or at the edge where the granted requester has req=0.
REQ-019 At grant end, ptr SHALL become (granted index + 1) mod NREQ, and the counter SHALL clear.
REQ-020 At grant end, gnt SHALL be reloaded in the same edge with the winner from the new ptr, so there is no idle bubble. If no req is set, the FSM goes to IDLE.
REQ-021 A sole active requester SHALL be re-granted after its burst ends, with no bubble.
REQ-022 Changes on req of a non-granted requester SHALL have no effect until the next arbitration edge.
REQ-023 At most one fifo_we SHALL occur per cycle, and never while fifo_full=1.

Reset
REQ-024 With rst=1 at an edge, the block SHALL clear gnt, set ptr=0, clear the counter and enter IDLE. This SHALL also occur mid-burst.
REQ-025 While rst=1, ack=0, fifo_we=0 and fifo_din=0 regardless of inputs.

Configuration
REQ-026 Macro FIFO_WR_ARBITER_STATS_EN, when defined, SHALL add input stat_clr (1 bit) and output stat_cnt (NREQ*16 bits).
REQ-027 Each stat_cnt field SHALL be a saturating count of that requester's ack pulses, cleared by rst or stat_clr. stat_clr has priority over an increment in the same cycle.
REQ-028 Without the macro, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold the FSM state type (IDLE, BUSY), the stats counter width constant (16), and a log2 helper for the ptr and counter widths.
REQ-030 Sub-module rr_pick SHALL be a combinational round-robin one-hot picker with inputs req and ptr, and outputs one-hot winner and a valid flag; it is instantiated once.

Verification
REQ-031 Single requester: req=0001, fifo_full=0, BURST=4, requester 0 holds req for 10 words -> gnt=0001 from cycle 1, 10 consecutive fifo_we, bubble-free re-grant after words 4 and 8.
REQ-032 All four requesters hold req continuously -> grant order 0,1,2,3,0, each grant 4 words; FIFO contents match a per-requester scoreboard in order.
REQ-033 fifo_full=1 for 3 cycles mid-burst of requester 2 -> ack=0 and fifo_we=0 for those 3 cycles; gnt held; burst completes with 4 total words.
REQ-034 Requester 1 drops req after 2 words while requester 3 is pending -> gnt moves to 1000 on the next edge and ptr=2.
REQ-035 rst=1 pulsed during the 3rd word of a burst -> next cycle gnt=0, fifo_we=0; after rst=0, arbitration restarts from requester 0.
REQ-036 With STATS_EN, 300 accepts on requester 0 then stat_clr=1 -> stat_cnt[0] reads 300, then 0 on the next cycle.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            vld
);

  always_comb begin
    win = '0;
    vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          win[i] = 1'b1;
          vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one shared sync FIFO write port.
// Optional per-requester accept counters under FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      gnt,
  input  logic                 fifo_full,
  output logic                 fifo_we,
`ifdef FIFO_WR_ARBITER_STATS_EN
  input  logic                 stat_clr,
  output logic [NREQ*STAT_W-1:0] stat_cnt,
`endif
  output logic [DW-1:0]        fifo_din
);

  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(BURST + 1);

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_n, pick_win;
  logic [PW-1:0]   ptr, ptr_n, ptr_next, pick_ptr, gidx;
  logic [CW-1:0]   cnt, cnt_n;
  logic            pick_vld, ack_any, grant_end;

  assign ack     = rst ? '0 : (gnt & req & {NREQ{~fifo_full}});
  assign ack_any = |ack;
  assign fifo_we = ack_any;

  always_comb begin
    gidx     = '0;
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx     = PW'(i);
        fifo_din = data[i*DW +: DW];
      end
    end
    if (rst) fifo_din = '0;
  end

  assign ptr_next  = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  // A grant ends on its last accepted word or as soon as its owner stops asking.
  assign grant_end = (state == BUSY) &&
                     (((gnt & req) == '0) || (ack_any && (cnt == CW'(BURST - 1))));
  assign pick_ptr  = grant_end ? ptr_next : ptr;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .win (pick_win),
    .vld (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n = BUSY;
          gnt_n   = pick_win;
        end
      end
      BUSY: begin
        if (grant_end) begin
          ptr_n = ptr_next;
          cnt_n = '0;
          if (pick_vld) begin
            gnt_n = pick_win;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else if (ack_any) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    logic [STAT_W-1:0] stat_q;
    always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
        stat_q <= '0;
      end else if (ack[g] && (stat_q != '1)) begin
        stat_q <= stat_q + STAT_W'(1);
      end
    end
    assign stat_cnt[g*STAT_W +: STAT_W] = stat_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; stats test runs when FIFO_WR_ARBITER_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   gnt;
  logic              fifo_full;
  logic              fifo_we;
  logic [DW-1:0]     fifo_din;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic              stat_clr;
  logic [NREQ*16-1:0] stat_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int wcnt [NREQ];
  logic [DW-1:0] fifo_q [$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .gnt       (gnt),
    .fifo_full (fifo_full),
    .fifo_we   (fifo_we),
`ifdef FIFO_WR_ARBITER_STATS_EN
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
`endif
    .fifo_din  (fifo_din)
  );

  // Requester i presents i*64 + (number of its words already accepted).
  always_comb begin
    for (int i = 0; i < NREQ; i++) data[i*DW +: DW] = DW'(i * 64 + wcnt[i]);
  end

  always @(negedge clk) begin
    if (fifo_we) fifo_q.push_back(fifo_din);
    for (int i = 0; i < NREQ; i++) if (ack[i]) wcnt[i] = wcnt[i] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; fifo_full = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
    fifo_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; fifo_full = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(); tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
    n_cmp++; if (fifo_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", fifo_we); end
    n_cmp++; if (fifo_din !== 8'h00) begin n_bad++; $display("FAIL reset_din got=%h want=00", fifo_din); end
    n_cmp++; if (dut.ptr !== 2'd0) begin n_bad++; $display("FAIL reset_ptr got=%0d want=0", dut.ptr); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_idle_gnt got=%b want=0000", gnt); end
    n_cmp++; if (fifo_we !== 1'b0) begin n_bad++; $display("FAIL single_idle_we got=%b want=0", fifo_we); end
    tick();
    for (int w = 0; w < 10; w++) begin
      n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt w=%0d got=%b want=0001", w, gnt); end
      n_cmp++; if (fifo_we !== 1'b1) begin n_bad++; $display("FAIL single_we w=%0d got=%b want=1", w, fifo_we); end
      n_cmp++; if (fifo_din !== 8'(w)) begin n_bad++; $display("FAIL single_din w=%0d got=%h want=%h", w, fifo_din, 8'(w)); end
      tick();
    end
    req = 4'b0000;
    #1;
    n_cmp++; if (fifo_we !== 1'b0) begin n_bad++; $display("FAIL single_drop_we got=%b want=0", fifo_we); end
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_end_gnt got=%b want=0000", gnt); end
    n_cmp++; if (fifo_q.size() !== 10) begin n_bad++; $display("FAIL single_count got=%0d want=10", fifo_q.size()); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req = 4'b1111;
    tick();
    for (int c = 0; c < 20; c++) begin
      exp_g = 4'b0001 << ((c / 4) % 4);
      n_cmp++; if (gnt !== exp_g) begin n_bad++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, exp_g); end
      n_cmp++; if (fifo_we !== 1'b1) begin n_bad++; $display("FAIL rr_we c=%0d got=%b want=1", c, fifo_we); end
      tick();
    end
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL rr_next_gnt got=%b want=0010", gnt); end
    req = 4'b0000;
    tick(); tick();
    n_cmp++; if (fifo_q.size() !== 20) begin n_bad++; $display("FAIL rr_count got=%0d want=20", fifo_q.size()); end
    for (int k = 0; k < 20 && k < fifo_q.size(); k++) begin
      exp_d = 8'(((k / 4) % 4) * 64 + (k % 4) + ((k >= 16) ? 4 : 0));
      n_cmp++; if (fifo_q[k] !== exp_d) begin n_bad++; $display("FAIL rr_fifo k=%0d got=%h want=%h", k, fifo_q[k], exp_d); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0110;
    for (int c = 0; c < 7; c++) begin
      fifo_full = (c >= 2 && c < 5);
      #1;
      n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL stall_gnt c=%0d got=%b want=0100", c, gnt); end
      if (fifo_full) begin
        n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL stall_ack c=%0d got=%b want=0000", c, ack); end
        n_cmp++; if (fifo_we !== 1'b0) begin n_bad++; $display("FAIL stall_we c=%0d got=%b want=0", c, fifo_we); end
      end else begin
        n_cmp++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL stall_ack c=%0d got=%b want=0100", c, ack); end
      end
      tick();
    end
    fifo_full = 1'b0;
    n_cmp++; if (wcnt[2] !== 4) begin n_bad++; $display("FAIL stall_words got=%0d want=4", wcnt[2]); end
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL stall_next_gnt got=%b want=0010", gnt); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1010;
    tick(); tick();
    req = 4'b1000;
    #1;
    n_cmp++; if (fifo_we !== 1'b0) begin n_bad++; $display("FAIL drop_we got=%b want=0", fifo_we); end
    n_cmp++; if (wcnt[1] !== 2) begin n_bad++; $display("FAIL drop_words got=%0d want=2", wcnt[1]); end
    tick();
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL drop_gnt got=%b want=1000", gnt); end
    n_cmp++; if (dut.ptr !== 2'd2) begin n_bad++; $display("FAIL drop_ptr got=%0d want=2", dut.ptr); end
    n_cmp++; if (fifo_din !== 8'hC0) begin n_bad++; $display("FAIL drop_din got=%h want=c0", fifo_din); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rmid_ack got=%b want=0000", ack); end
    n_cmp++; if (fifo_we !== 1'b0) begin n_bad++; $display("FAIL rmid_we got=%b want=0", fifo_we); end
    n_cmp++; if (fifo_din !== 8'h00) begin n_bad++; $display("FAIL rmid_din got=%h want=00", fifo_din); end
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rmid_gnt got=%b want=0000", gnt); end
    n_cmp++; if (wcnt[2] !== 2) begin n_bad++; $display("FAIL rmid_words got=%0d want=2", wcnt[2]); end
    rst = 1'b0;
    req = 4'b1111;
    #1;
    n_cmp++; if (fifo_we !== 1'b0) begin n_bad++; $display("FAIL rmid_idle_we got=%b want=0", fifo_we); end
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rmid_restart got=%b want=0001", gnt); end
    req = 4'b0000;
    tick(); tick();
  endtask

`ifdef FIFO_WR_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 300; c++) tick();
    req = 4'b0000;
    stat_clr = 1'b1;
    #1;
    n_cmp++; if (stat_cnt[15:0] !== 16'd300) begin n_bad++; $display("FAIL stat_cnt got=%0d want=300", stat_cnt[15:0]); end
    tick();
    stat_clr = 1'b0;
    n_cmp++; if (stat_cnt[15:0] !== 16'd0) begin n_bad++; $display("FAIL stat_clr got=%0d want=0", stat_cnt[15:0]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_drop();
    test_reset_mid();
`ifdef FIFO_WR_ARBITER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
